// File: rtl/pwm_dec_pkg.sv
// Shared types and constants for the PWM decoder: FSM states, error codes, default width.
package pwm_dec_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;
    localparam int unsigned ERR_CODE_W    = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [ERR_CODE_W-1:0] ERR_SHAPE   = 2'd0;
    localparam logic [ERR_CODE_W-1:0] ERR_OVERRUN = 2'd1;
    localparam logic [ERR_CODE_W-1:0] ERR_SAT     = 2'd2;
    localparam logic [ERR_CODE_W-1:0] ERR_ABORT   = 2'd3;

    typedef struct packed {
        logic                  flag;
        logic [ERR_CODE_W-1:0] code;
    } err_t;

endpackage

// File: rtl/pwm_decoder_frame_counter.sv
// Frame cycle index for the PWM decoder; tc flags the final cycle of a frame.
module frame_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             res,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] idx,
    output logic             tc
);

    // Index is cleared on the sof cycle, so in frame cycle k it holds k-1.
    localparam logic [WIDTH-1:0] LAST_STEP = {{(WIDTH-1){1'b1}}, 1'b0};

    always_ff @(posedge clock) begin
        if (res || clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + WIDTH'(1);
        end
    end

    assign tc = inc && (idx == LAST_STEP);

endmodule

// File: rtl/pwm_decoder.sv
// PWM decoder: measures the high time of a pulse per 2^WIDTH-cycle frame and hands the
// count out over a valid/ready port. Define PWM_DEC_SHAPE_CHECK_EN to flag re-rising pulses.
module pwm_decoder
    import pwm_dec_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             res,
    input  logic             pulse_in,
    input  logic             sof,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int unsigned CW = WIDTH + 1;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] idx;
    logic             tc;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_sum;
    logic [WIDTH-1:0] result;
    logic             sat;
    logic             frame_end;
    logic             abort;
    logic             wr;
    logic             ovr;
    logic             busy_d;
    logic             shape_hit;
    err_t             err_nx;

    frame_counter #(
        .WIDTH (WIDTH)
    ) u_frame_counter (
        .clock (clock),
        .res   (res),
        .clr   (sof),
        .inc   (state == MEASURE),
        .idx   (idx),
        .tc    (tc)
    );

    // State register
    always_ff @(posedge clock) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; sof always (re)starts a frame
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (sof) begin
                    state_nx = MEASURE;
                end
            end
            MEASURE: begin
                if (sof) begin
                    state_nx = MEASURE;
                end else if (tc) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Frame-end result, handshake and error selection
    always_comb begin
        abort     = 1'b0;
        frame_end = 1'b0;
        wr        = 1'b0;
        ovr       = 1'b0;
        busy_d    = (state_nx == MEASURE);
        count_sum = count + CW'(pulse_in);
        sat       = count_sum[WIDTH];
        result    = sat ? '1 : count_sum[WIDTH-1:0];
        err_nx    = '{flag: 1'b0, code: ERR_SHAPE};

        if (state == MEASURE) begin
            abort     = sof;
            frame_end = !sof && tc;
        end
        wr  = frame_end && (!out_valid || out_ready);
        ovr = frame_end && out_valid && !out_ready;

        if (abort) begin
            err_nx = '{flag: 1'b1, code: ERR_ABORT};
        end else if (ovr) begin
            err_nx = '{flag: 1'b1, code: ERR_OVERRUN};
        end else if (frame_end && sat) begin
            err_nx = '{flag: 1'b1, code: ERR_SAT};
        end else if (shape_hit) begin
            err_nx = '{flag: 1'b1, code: ERR_SHAPE};
        end
    end

`ifdef PWM_DEC_SHAPE_CHECK_EN
    logic prev_pulse;
    logic shape_seen;

    // A rising pulse_in after frame cycle 0 means the pulse was not one contiguous run.
    always_ff @(posedge clock) begin
        if (res) begin
            prev_pulse <= 1'b0;
            shape_seen <= 1'b0;
        end else if (sof) begin
            prev_pulse <= pulse_in;
            shape_seen <= 1'b0;
        end else if (state == MEASURE) begin
            prev_pulse <= pulse_in;
            if (shape_hit) begin
                shape_seen <= 1'b1;
            end
        end
    end

    assign shape_hit = (state == MEASURE) && !sof && pulse_in && !prev_pulse && !shape_seen;
`else
    assign shape_hit = 1'b0;
`endif

    // Count accumulation and registered outputs
    always_ff @(posedge clock) begin
        if (res) begin
            count     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_SHAPE;
        end else begin
            if (sof) begin
                count <= CW'(pulse_in);
            end else if (state == MEASURE) begin
                count <= count_sum;
            end

            if (wr) begin
                out <= result;
            end

            if (wr) begin
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            busy     <= busy_d;
            err      <= err_nx.flag;
            err_code <= err_nx.code;
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench for pwm_decoder: frame-level reference model feeds expected results and
// error events into queues that a monitor matches against DUT handshakes and err pulses.
module tb_pwm_decoder;

    localparam int unsigned W  = 4;
    localparam int unsigned FR = 1 << W;

    localparam logic [1:0] C_SHAPE   = 2'd0;
    localparam logic [1:0] C_OVERRUN = 2'd1;
    localparam logic [1:0] C_SAT     = 2'd2;
    localparam logic [1:0] C_ABORT   = 2'd3;

`ifdef PWM_DEC_SHAPE_CHECK_EN
    localparam bit SHAPE_EN = 1'b1;
`else
    localparam bit SHAPE_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         res = 1'b1;
    logic         pulse_in = 1'b1;
    logic         sof = 1'b1;
    logic         out_ready = 1'b0;
    logic [W-1:0] out;
    logic         out_valid;
    logic         busy;
    logic         err;
    logic [1:0]   err_code;

    pwm_decoder #(.WIDTH(W)) dut (
        .clock     (clock),
        .res       (res),
        .pulse_in  (pulse_in),
        .sof       (sof),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t exp_out[$];
    exp_t exp_err[$];
    int   checks = 0;
    int   errors = 0;
    bit   held = 1'b0;
    int   now = 0;

    function automatic void chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, expv, cyc);
        end
    endfunction

    function automatic void push_out(int c, int v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        exp_out.push_back(e);
    endfunction

    function automatic void push_err(int c, logic [1:0] code);
        exp_t e;
        e.cyc = c;
        e.val = int'(code);
        exp_err.push_back(e);
    endfunction

    function automatic logic pick_ready(int mode);
        if (mode == 2) return 1'($urandom_range(1, 0));
        return (mode != 0);
    endfunction

    task automatic drive(input logic s, input logic p, input logic r);
        @(posedge clock);
        #1;
        sof       = s;
        pulse_in  = p;
        out_ready = r;
        now       = cyc;
    endtask

    task automatic idle(input int n, input int rmode);
        logic r;
        for (int i = 0; i < n; i++) begin
            r = pick_ready(rmode);
            drive(1'b0, 1'($urandom_range(1, 0)), r);
            if (held && r) held = 1'b0;
        end
    endtask

    // Drives one frame (len < FR means the next frame's sof will cut it short).
    task automatic run_frame(input logic [FR-1:0] bits, input int len, input int rmode,
                             input bit aborting);
        int   val;
        bit   shape_done;
        bit   shape_now;
        logic r;
        val        = 0;
        shape_done = 1'b0;
        for (int k = 0; k < len; k++) begin
            r = pick_ready(rmode);
            drive(k == 0, bits[k], r);
            shape_now = 1'b0;
            if (k > 0) shape_now = SHAPE_EN && bits[k] && !bits[k-1] && !shape_done;
            if (shape_now) shape_done = 1'b1;
            val += int'(bits[k]);
            if (k == 0 && aborting) push_err(now + 1, C_ABORT);
            if (k == FR - 1) begin
                if (!held || r) begin
                    push_out(now + 1, (val == FR) ? FR - 1 : val);
                    held = 1'b1;
                    if (val == FR) push_err(now + 1, C_SAT);
                    else if (shape_now) push_err(now + 1, C_SHAPE);
                end else begin
                    push_err(now + 1, C_OVERRUN);
                end
            end else begin
                if (held && r) held = 1'b0;
                if (shape_now) push_err(now + 1, C_SHAPE);
            end
        end
    endtask

    // Monitor: pops expectations on every handshake and every err pulse
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    chk("out_unexpected", 1, 0);
                end else begin
                    e = exp_out.pop_front();
                    chk("out_value", int'(out), e.val);
                    chk("out_not_early", int'(cyc >= e.cyc), 1);
                end
            end
            if (err) begin
                if (exp_err.size() == 0) begin
                    chk("err_unexpected", int'(err_code), -1);
                end else begin
                    e = exp_err.pop_front();
                    chk("err_code", int'(err_code), e.val);
                    chk("err_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        bit pend_abort;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out", int'(out), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_code", int'(err_code), 0);
        res = 1'b0;
        sof = 1'b0;
        pulse_in = 1'b0;

        // Value 9, ready high throughout
        run_frame(16'h01FF, FR, 1, 1'b0);
        idle(3, 1);

        // Full-high frame saturates
        run_frame(16'hFFFF, FR, 1, 1'b0);
        idle(2, 1);

        // Back-to-back 3 and 12 with ready low: 12 overruns, 3 is held
        run_frame(16'h0007, FR, 0, 1'b0);
        run_frame(16'h0FFF, FR, 0, 1'b0);
        idle(3, 0);
        @(negedge clock);
        chk("held_out", int'(out), 3);
        chk("held_valid", int'(out_valid), 1);
        idle(1, 1);
        idle(1, 1);
        @(negedge clock);
        chk("valid_drop", int'(out_valid), 0);

        // Abort at frame cycle 7, restarted frame decodes 5
        run_frame(16'h3F3F, 7, 1, 1'b0);
        run_frame(16'h001F, FR, 1, 1'b1);
        idle(2, 1);

        // Pattern 1,1,0,1: value 3, shape error only when checking is built in
        run_frame(16'h000B, FR, 1, 1'b0);
        idle(2, 1);

        // Reset in frame cycle 10 discards the frame
        run_frame(16'h03FF, 10, 1, 1'b0);
        @(negedge clock);
        chk("busy_mid_frame", int'(busy), 1);
        @(posedge clock);
        #1;
        res = 1'b1;
        sof = 1'b0;
        held = 1'b0;
        @(posedge clock);
        #1;
        res = 1'b0;
        @(negedge clock);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_valid", int'(out_valid), 0);
        run_frame(16'h007F, FR, 1, 1'b0);
        idle(2, 1);

        // Randomized frames, ready patterns, gaps and aborts
        pend_abort = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [FR-1:0] bits;
            int            len;
            int            v;
            if ($urandom_range(1, 0) == 1) begin
                v    = int'($urandom_range(FR, 0));
                bits = FR'((1 << v) - 1);
            end else begin
                bits = FR'($urandom);
            end
            len = ($urandom_range(4, 0) == 0) ? int'($urandom_range(FR - 1, 1)) : FR;
            run_frame(bits, len, int'($urandom_range(2, 0)), pend_abort);
            pend_abort = (len < FR);
            if (!pend_abort) idle(int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
        end
        if (pend_abort) run_frame(16'h00FF, FR, 1, 1'b1);

        idle(6, 1);
        @(negedge clock);
        chk("exp_out_left", exp_out.size(), 0);
        chk("exp_err_left", exp_err.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 Parameter WIDTH, default 4: value width; frame length is 2^WIDTH cycles (16 at default).
REQ-002 clock  input  1  the single clock; all logic rising-edge.
REQ-003 res  input  1  reset, synchronous, active-high.
REQ-004 pulse_in  input  1  encoded pulse stream, high for `value` cycles from frame start.
REQ-005 sof  input  1  start-of-frame strobe; the cycle it is high is frame cycle 0.
REQ-006 out  output  WIDTH  decoded value.
REQ-007 out_valid  output  1  out holds an unconsumed result.
REQ-008 out_ready  input  1  consumer accepts out when out_valid and out_ready are both high.
REQ-009 busy  output  1  high while a frame is being measured.
REQ-010 err  output  1  single-cycle error pulse.
REQ-011 err_code  output  2  cause of the err pulse, valid only while err is high.

Function
REQ-012 SHALL have states IDLE and MEASURE; busy SHALL be high exactly in MEASURE.
REQ-013 IDLE -> MEASURE on sof; the count SHALL be loaded with pulse_in of that cycle (0 or 1) and the frame cycle index set to 0.
REQ-014 In MEASURE, each cycle SHALL increment the frame index and add pulse_in to the count; the frame SHALL end at index 2^WIDTH-1, returning to IDLE.
REQ-015 Count SHALL be WIDTH+1 bits internally; a final count of 2^WIDTH SHALL saturate out to 2^WIDTH-1 and raise err, code SAT (2'd2).
REQ-016 At frame end, if out_valid is low or out_ready is high that cycle, the result SHALL be written to out and out_valid SHALL be high the next cycle (latency: one cycle after last frame cycle).
REQ-017 At frame end, if out_valid is high and out_ready is low, the result SHALL be dropped, out unchanged, and err raised with code OVERRUN (2'd1).
REQ-018 out_valid SHALL clear on a handshake, unless a new result is written in the same cycle, in which case it stays high with the new value.
REQ-019 sof in MEASURE (including the last frame cycle) SHALL abort the current frame without output, raise err with code ABORT (2'd3), and start a new frame per REQ-013.
REQ-020 sof the cycle immediately after a frame end SHALL start a new frame with no error (back-to-back frames).
REQ-021 pulse_in outside MEASURE and without sof SHALL be ignored.
REQ-022 Simultaneous error causes SHALL report priority ABORT > OVERRUN > SAT > SHAPE.

Reset
REQ-023 While res is high: state IDLE, count 0, frame index 0, out 0, out_valid 0, busy 0, err 0, err_code 0; res SHALL override sof.
REQ-024 res mid-frame SHALL discard the partial count; a held result SHALL be discarded.

Configuration
REQ-025 With PWM_DEC_SHAPE_CHECK_EN defined, a 0->1 transition of pulse_in within a frame after the pulse has gone low SHALL raise err with code SHAPE (2'd0) once per frame; counting continues unchanged.
REQ-026 Without PWM_DEC_SHAPE_CHECK_EN, no shape tracking logic SHALL exist and code SHAPE SHALL never occur.

Structure
REQ-027 Package pwm_dec_pkg SHALL hold the state enum, err_code constants (SHAPE, OVERRUN, SAT, ABORT) and the WIDTH default.
REQ-028 The frame index SHALL be a sub-module frame_counter (synchronous clear on res or sof, increment, terminal-count output).

Verification
REQ-029 sof at t0, pulse_in high t0..t8 (9 cycles), out_ready=1 -> out=9, out_valid high at t16 for one cycle, err never high.
REQ-030 pulse_in high all 16 cycles -> out=15, err pulse with code 2'd2 at frame end.
REQ-031 Two back-to-back frames of values 3 and 12, out_ready=0 -> out=3 held, err code 2'd1 at second frame end; then out_ready=1 -> out_valid drops.
REQ-032 sof at t0, second sof at t7 with value 5 -> err code 2'd3 at t7, out=5 at t23, no output from the aborted frame.
REQ-033 Pulse pattern 1,1,0,1 then low, macro defined -> out=3, err code 2'd0 once; macro undefined -> out=3, no err.
REQ-034 res asserted at frame cycle 10 -> busy=0, out_valid=0 next cycle; the following sof frame decodes correctly.
